slice_reg_pipe: RTL

SLICE_REG_PIPE -- requirements
Module: slice_reg_pipe

---
 rtl/slice_reg_pipe.sv | 92 +++++++++
 1 files changed

// File: rtl/slice_reg_pipe.sv
// Elastic register-slice pipeline: DEPTH stages of data+valid with ready/valid handshake,
// clock enable, synchronous local set/reset/preload and asynchronous global reset.
module slice_reg_pipe #(
    parameter int    WIDTH   = 8,
    parameter int    DEPTH   = 2,
    parameter string REGSET  = "RESET",
    parameter string SRMODE  = "LSR_OVER_CE",
    parameter string LSRMODE = "LSR",
    parameter string GSR     = "ENABLED"
) (
    input  logic             CLK,
    input  logic             GSR_N,
    input  logic             CE,
    input  logic             LSR,
    input  logic [WIDTH-1:0] M,
    input  logic [WIDTH-1:0] DI,
    input  logic             DI_VALID,
    output logic             DI_READY,
    output logic [WIDTH-1:0] DO,
    output logic             DO_VALID,
    input  logic             DO_READY
);

    localparam logic [WIDTH-1:0] REG_VAL  = (REGSET == "SET") ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam bit               LSR_PRIO = (SRMODE == "LSR_OVER_CE");
    localparam bit               PRELOAD  = (LSRMODE == "PRLD");

    logic [WIDTH-1:0] d     [DEPTH];
    logic [WIDTH-1:0] d_nxt [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_nxt;
    logic [DEPTH-1:0] acc;
    logic             lsr_eff;

    assign lsr_eff = LSR & (LSR_PRIO | CE);

    // acc[k] is set when stage k can take a word: any stage at or above it is empty,
    // or the tail drains; this is what collapses bubbles while the output stalls.
    always_comb begin : acc_chain
        logic a;
        acc = '0;
        a = ~v[DEPTH-1] | DO_READY;
        acc[DEPTH-1] = a;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            a = ~v[k] | a;
            acc[k] = a;
        end
    end

    assign DI_READY = GSR_N & CE & acc[0] & ~lsr_eff;

    always_comb begin
        v_nxt = v;
        for (int k = 0; k < DEPTH; k++) d_nxt[k] = d[k];
        if (lsr_eff) begin
            v_nxt = {DEPTH{PRELOAD}};
            for (int k = 0; k < DEPTH; k++) d_nxt[k] = PRELOAD ? M : REG_VAL;
        end else if (CE) begin
            if (acc[0]) begin
                d_nxt[0] = DI;
                v_nxt[0] = DI_VALID;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (acc[k]) begin
                    d_nxt[k] = d[k-1];
                    v_nxt[k] = v[k-1];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge GSR_N) begin
        if (!GSR_N) v <= '0;
        else        v <= v_nxt;
    end

    // Data registers only see the global reset when GSR is enabled.
    if (GSR == "ENABLED") begin : g_gsr
        always_ff @(posedge CLK or negedge GSR_N) begin
            if (!GSR_N) for (int k = 0; k < DEPTH; k++) d[k] <= REG_VAL;
            else        for (int k = 0; k < DEPTH; k++) d[k] <= d_nxt[k];
        end
    end else begin : g_nogsr
        always_ff @(posedge CLK) begin
            for (int k = 0; k < DEPTH; k++) d[k] <= d_nxt[k];
        end
    end

    assign DO       = d[DEPTH-1];
    assign DO_VALID = v[DEPTH-1];

endmodule
